// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: per-job K-tile loop for the 8x8 systolic array.
// Each tile fetches weights and activations, loads the weights, feeds a skewed
// activation vector, flushes, and captures the result. After the last tile it
// drains the accumulated column results over a valid/ready port.
module sa_tile_sequencer #(
  parameter int DIM     = 8,
  parameter int DW      = 8,
  parameter int AW      = 32,
  parameter int KTW     = 4,
  parameter int ADDRW   = 8,
  parameter int CAP_LAT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KTW-1:0]           num_k_tiles,
  output logic                     busy,
  output logic                     done,
  output logic                     op_rd_en,
  output logic [ADDRW-1:0]         op_rd_addr,
  input  logic [DIM*DW-1:0]        op_rd_data,
  output logic                     sa_enable_cycle,
  output logic                     sa_load_W,
  output logic                     sa_accumulate_mode,
  output logic                     sa_capture_en,
  output logic [DIM*DW-1:0]        sa_row_inputs,
  output logic [$clog2(DIM)-1:0]   sa_col_sel,
  input  logic [AW-1:0]            sa_data_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [AW-1:0]            res_data,
  output logic [$clog2(DIM)-1:0]   res_col
);

  localparam int CSW = $clog2(DIM);
  localparam int CW  = $clog2(CAP_LAT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, FEED, FLUSH, CAPTURE, DRAIN} state_t;

  state_t                 state_q, state_n;
  logic [CW-1:0]          cyc_q, cyc_n;
  logic [KTW-1:0]         tile_q, tile_n, count_q, count_n;
  logic [KTW:0]           tile_inc;
  logic [ADDRW-1:0]       base_q, base_n;
  logic [CSW-1:0]         col_q, col_n;
  logic [(DIM-1)*DW-1:0]  act_q;

  logic                   busy_n, done_n, rd_en_n, en_n, load_n, acc_n, cap_n, valid_n;
  logic [ADDRW-1:0]       rd_addr_n;

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_n  = state_q;
    cyc_n    = cyc_q;
    tile_n   = tile_q;
    count_n  = count_q;
    base_n   = base_q;
    col_n    = col_q;
    done_n   = 1'b0;
    tile_inc = {1'b0, tile_q} + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          tile_n  = '0;
          base_n  = '0;
          count_n = (num_k_tiles == '0) ? KTW'(1) : num_k_tiles;
        end
      end
      FETCH: begin
        state_n = LOAD;
        cyc_n   = '0;
      end
      LOAD: begin
        if (cyc_q == CW'(DIM - 1)) begin
          state_n = FEED;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + 1'b1;
        end
      end
      FEED, FLUSH: begin
        cyc_n = cyc_q + 1'b1;
        if (cyc_n == CW'(CAP_LAT)) state_n = CAPTURE;
        else if (cyc_n >= CW'(DIM)) state_n = FLUSH;
      end
      CAPTURE: begin
        tile_n = tile_inc[KTW-1:0];
        base_n = base_q + ADDRW'(DIM + 1);
        if (tile_inc < {1'b0, count_q}) begin
          state_n = FETCH;
        end else begin
          state_n = DRAIN;
          col_n   = '0;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          col_n = col_q + 1'b1;
          if (col_q == CSW'(DIM - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Reads run one word ahead of the LOAD cycle so each word lands on time;
    // the last LOAD cycle therefore fetches the activation word.
    busy_n    = (state_n != IDLE);
    rd_en_n   = (state_n == FETCH) || (state_n == LOAD);
    rd_addr_n = '0;
    if (rd_en_n) rd_addr_n = base_n + ((state_n == LOAD) ? ADDRW'(cyc_n) + ADDRW'(1) : '0);
    en_n      = (state_n == LOAD) || (state_n == FEED) || (state_n == FLUSH) || (state_n == CAPTURE);
    load_n    = (state_n == LOAD);
    cap_n     = (state_n == CAPTURE);
    acc_n     = (state_n == CAPTURE) && (tile_n != '0);
    valid_n   = (state_n == DRAIN);
  end

  // State register and job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      tile_q  <= '0;
      count_q <= '0;
      base_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      tile_q  <= tile_n;
      count_q <= count_n;
      base_q  <= base_n;
      col_q   <= col_n;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy               <= 1'b0;
      done               <= 1'b0;
      op_rd_en           <= 1'b0;
      op_rd_addr         <= '0;
      sa_enable_cycle    <= 1'b0;
      sa_load_W          <= 1'b0;
      sa_accumulate_mode <= 1'b0;
      sa_capture_en      <= 1'b0;
      res_valid          <= 1'b0;
    end else begin
      busy               <= busy_n;
      done               <= done_n;
      op_rd_en           <= rd_en_n;
      op_rd_addr         <= rd_addr_n;
      sa_enable_cycle    <= en_n;
      sa_load_W          <= load_n;
      sa_accumulate_mode <= acc_n;
      sa_capture_en      <= cap_n;
      res_valid          <= valid_n;
    end
  end

  // Activation rows 1..DIM-1 are held from FEED cycle 0 to build the skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_q <= '0;
    else if (state_q == FEED && cyc_q == '0) act_q <= op_rd_data[DIM*DW-1:DW];
  end

  // Row drive: weight words and row 0 of the activation are forwarded straight
  // from the SRAM read register (1-cycle read latency), selected by registered
  // state; row r sees its activation element only at compute cycle r.
  always_comb begin
    sa_row_inputs = '0;
    if (state_q == LOAD) begin
      sa_row_inputs = op_rd_data;
    end else if (state_q == FEED) begin
      if (cyc_q == '0) sa_row_inputs[DW-1:0] = op_rd_data[DW-1:0];
      for (int unsigned r = 1; r < DIM; r++) begin
        if (cyc_q == CW'(r)) sa_row_inputs[r*DW +: DW] = act_q[(r-1)*DW +: DW];
      end
    end
  end

  assign sa_col_sel = col_q;
  assign res_col    = col_q;
  assign res_data   = sa_data_in;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: operand SRAM and array behavioural models,
// result scoreboard, and one task per scenario.
module tb_sa_tile_sequencer;

  localparam int DIM = 8, DW = 8, AW = 32, KTW = 4, ADDRW = 8, CAP_LAT = 15;

  logic                 clk = 1'b0;
  logic                 rst_n, start, res_ready;
  logic [KTW-1:0]       num_k_tiles;
  logic                 busy, done, op_rd_en;
  logic [ADDRW-1:0]     op_rd_addr;
  logic [DIM*DW-1:0]    op_rd_data = '0;
  logic                 sa_enable_cycle, sa_load_W, sa_accumulate_mode, sa_capture_en;
  logic [DIM*DW-1:0]    sa_row_inputs;
  logic [2:0]           sa_col_sel, res_col;
  logic [AW-1:0]        sa_data_in, res_data;
  logic                 res_valid;

  sa_tile_sequencer #(.DIM(DIM), .DW(DW), .AW(AW), .KTW(KTW), .ADDRW(ADDRW), .CAP_LAT(CAP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_k_tiles(num_k_tiles),
    .busy(busy), .done(done), .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .op_rd_data(op_rd_data), .sa_enable_cycle(sa_enable_cycle), .sa_load_W(sa_load_W),
    .sa_accumulate_mode(sa_accumulate_mode), .sa_capture_en(sa_capture_en),
    .sa_row_inputs(sa_row_inputs), .sa_col_sel(sa_col_sel), .sa_data_in(sa_data_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_col(res_col)
  );

  always #5 clk = ~clk;

  // Operand SRAM: data valid one cycle after the read strobe.
  logic [DIM*DW-1:0] mem [256];
  always @(posedge clk) if (op_rd_en) op_rd_data <= mem[op_rd_addr];

  // Array model: weights captured in LOAD, activations taken from the skewed rows.
  logic [AW-1:0]     buf_m [DIM];
  logic [DIM*DW-1:0] w_m   [DIM];
  logic [DW-1:0]     act_m [DIM];
  assign sa_data_in = buf_m[sa_col_sel];

  int tests_run = 0, failed = 0;
  int ld_idx = 0, comp = 0, skew_err = 0, hold_err = 0, overlap_err = 0, done_cnt = 0;
  int cap_comp_q[$];
  bit acc_q[$];
  logic [AW-1:0] exp_q[$];
  logic [2:0]    expc_q[$];
  bit            prev_stall = 0;
  logic [2:0]    prev_col;
  logic [AW-1:0] prev_data;

  always @(negedge clk) begin
    logic [AW-1:0] sum, ed;
    logic [DW-1:0] row;
    logic [2:0]    ec;
    #1;
    if (!rst_n) begin
      ld_idx = 0; comp = 0; prev_stall = 0;
    end else begin
      if (sa_load_W && sa_capture_en) overlap_err++;
      if (sa_load_W) begin
        if (ld_idx < DIM) w_m[ld_idx] = sa_row_inputs;
        ld_idx++;
        comp = 0;
      end else if (sa_enable_cycle) begin
        if (sa_capture_en) begin
          cap_comp_q.push_back(comp);
          acc_q.push_back(sa_accumulate_mode);
          for (int c = 0; c < DIM; c++) begin
            sum = '0;
            for (int r = 0; r < DIM; r++) sum += AW'(act_m[r]) * AW'(w_m[r][c*DW +: DW]);
            buf_m[c] = sa_accumulate_mode ? buf_m[c] + sum : sum;
          end
          ld_idx = 0;
        end else begin
          for (int r = 0; r < DIM; r++) begin
            row = sa_row_inputs[r*DW +: DW];
            if (row !== ((comp == r) ? DW'(r + 1) : DW'(0))) skew_err++;
            if (comp == r) act_m[r] = row;
          end
        end
        comp++;
      end else if (sa_row_inputs !== '0) skew_err++;

      if (prev_stall && (res_valid !== 1'b1 || sa_col_sel !== prev_col ||
                         res_col !== prev_col || res_data !== prev_data)) hold_err++;
      if (res_valid && res_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL scoreboard_extra: got col=%0d data=%0d, required no result", res_col, res_data);
        end else begin
          ed = exp_q.pop_front();
          ec = expc_q.pop_front();
          if (res_data !== ed || res_col !== ec) begin
            failed++;
            $display("FAIL scoreboard: got col=%0d data=%0d, required col=%0d data=%0d", res_col, res_data, ec, ed);
          end
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_col   = sa_col_sel;
      prev_data  = res_data;
      if (done) done_cnt++;
    end
  end

  // Drives one job from a negedge; returns cycles from start to done (bounded).
  task automatic run_job(input logic [KTW-1:0] nk, input int eff, input bit bp,
                         input int pulse_at, output int lat, output logic busy1);
    int k;
    for (int c = 0; c < DIM; c++) begin
      exp_q.push_back(AW'(eff * (c + 1)));
      expc_q.push_back(3'(c));
    end
    num_k_tiles = nk; start = 1'b1; res_ready = 1'b1; k = 0;
    @(negedge clk);
    start = 1'b0; lat = 1; busy1 = busy;
    while (lat < 3000) begin
      if (done === 1'b1) break;
      start = (lat == pulse_at);
      if (start) num_k_tiles = 4'd5;
      if (bp && res_valid === 1'b1) begin
        res_ready = (k % 3 == 0);
        k++;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; res_ready = 1'b1;
  endtask

  task automatic clear_obs();
    cap_comp_q.delete(); acc_q.delete(); skew_err = 0; hold_err = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, op_rd_en, op_rd_addr, sa_enable_cycle, sa_load_W, sa_accumulate_mode,
         sa_capture_en, sa_col_sel, res_valid, res_col} !== '0) begin
      failed++; $display("FAIL reset_ctrl: outputs not all zero (busy=%b done=%b rd_en=%b)", busy, done, op_rd_en);
    end
    tests_run++;
    if (sa_row_inputs !== '0) begin
      failed++; $display("FAIL reset_rows: got %h, required 0", sa_row_inputs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_tile();
    int lat, d0; logic b1;
    clear_obs(); d0 = done_cnt;
    run_job(4'd1, 1, 1'b0, -1, lat, b1);
    repeat (2) @(negedge clk);
    tests_run++; if (lat !== 34) begin failed++; $display("FAIL single_latency: got %0d, required 34", lat); end
    tests_run++; if (b1 !== 1'b1) begin failed++; $display("FAIL single_busy: got %b, required 1", b1); end
    tests_run++; if (acc_q.size() !== 1 || acc_q[0] !== 1'b0) begin
      failed++; $display("FAIL single_acc: got %0d captures, required 1 overwrite", acc_q.size()); end
    tests_run++; if (cap_comp_q.size() !== 1 || cap_comp_q[0] !== 15) begin
      failed++; $display("FAIL capture_cycle: got %0d captures, required 1 at compute cycle 15", cap_comp_q.size()); end
    tests_run++; if (skew_err !== 0) begin failed++; $display("FAIL skew: got %0d bad row samples, required 0", skew_err); end
    tests_run++; if (exp_q.size() !== 0) begin failed++; $display("FAIL single_drain: %0d results missing, required 0", exp_q.size()); end
    tests_run++; if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      failed++; $display("FAIL single_done: got %0d pulses busy=%b, required 1 and 0", done_cnt - d0, busy); end
  endtask

  task automatic test_multi_tile();
    int lat; logic b1;
    clear_obs();
    run_job(4'd3, 3, 1'b0, -1, lat, b1);
    repeat (2) @(negedge clk);
    tests_run++; if (lat !== 84) begin failed++; $display("FAIL multi_latency: got %0d, required 84", lat); end
    tests_run++; if (acc_q.size() !== 3 || acc_q[0] !== 1'b0 || acc_q[1] !== 1'b1 || acc_q[2] !== 1'b1) begin
      failed++; $display("FAIL multi_acc: got %0d captures, required pattern 0,1,1", acc_q.size()); end
    tests_run++; if (cap_comp_q.size() !== 3 || cap_comp_q[2] !== 15) begin
      failed++; $display("FAIL multi_capture: got %0d captures, required 3 at compute cycle 15", cap_comp_q.size()); end
    tests_run++; if (skew_err !== 0) begin failed++; $display("FAIL multi_skew: got %0d bad row samples, required 0", skew_err); end
    tests_run++; if (exp_q.size() !== 0) begin failed++; $display("FAIL multi_drain: %0d results missing, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int lat, d0; logic b1;
    clear_obs(); d0 = done_cnt;
    run_job(4'd1, 1, 1'b1, -1, lat, b1);
    repeat (3) @(negedge clk);
    tests_run++; if (lat !== 48) begin failed++; $display("FAIL bp_latency: got %0d, required 48", lat); end
    tests_run++; if (hold_err !== 0) begin failed++; $display("FAIL bp_hold: got %0d unstable stalls, required 0", hold_err); end
    tests_run++; if (exp_q.size() !== 0) begin failed++; $display("FAIL bp_drain: %0d results missing, required 0", exp_q.size()); end
    tests_run++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL bp_done: got %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_start_ignored();
    int lat, d0; logic b1;
    clear_obs(); d0 = done_cnt;
    run_job(4'd1, 1, 1'b0, 12, lat, b1);
    repeat (5) @(negedge clk);
    tests_run++; if (lat !== 34 || acc_q.size() !== 1) begin
      failed++; $display("FAIL busy_start_latency: got %0d cycles %0d captures, required 34 and 1", lat, acc_q.size()); end
    tests_run++; if (busy !== 1'b0 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      failed++; $display("FAIL busy_start_queued: busy=%b pulses=%0d left=%0d, required 0,1,0", busy, done_cnt - d0, exp_q.size()); end
    clear_obs();
    run_job(4'd0, 1, 1'b0, -1, lat, b1);
    repeat (2) @(negedge clk);
    tests_run++; if (lat !== 34 || acc_q.size() !== 1) begin
      failed++; $display("FAIL zero_count: got %0d cycles %0d captures, required 34 and 1", lat, acc_q.size()); end
    tests_run++; if (exp_q.size() !== 0) begin failed++; $display("FAIL zero_drain: %0d results missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_job();
    int lat, d0; logic b1;
    clear_obs(); d0 = done_cnt;
    num_k_tiles = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, op_rd_en, op_rd_addr, sa_enable_cycle, sa_load_W, sa_accumulate_mode,
         sa_capture_en, sa_col_sel, res_valid, res_col} !== '0 || sa_row_inputs !== '0) begin
      failed++; $display("FAIL midreset_outputs: busy=%b en=%b rows=%h, required all 0", busy, sa_enable_cycle, sa_row_inputs);
    end
    repeat (3) @(negedge clk);
    tests_run++; if (done_cnt !== d0 || acc_q.size() !== 1) begin
      failed++; $display("FAIL midreset_done: got %0d pulses %0d captures, required 0 and 1", done_cnt - d0, acc_q.size()); end
    rst_n = 1'b1;
    exp_q.delete(); expc_q.delete();
    repeat (2) @(negedge clk);
    clear_obs();
    run_job(4'd2, 2, 1'b0, -1, lat, b1);
    repeat (2) @(negedge clk);
    tests_run++; if (lat !== 59) begin failed++; $display("FAIL postreset_latency: got %0d, required 59", lat); end
    tests_run++; if (acc_q.size() !== 2 || acc_q[0] !== 1'b0 || acc_q[1] !== 1'b1) begin
      failed++; $display("FAIL postreset_acc: got %0d captures, required pattern 0,1", acc_q.size()); end
    tests_run++; if (exp_q.size() !== 0 || overlap_err !== 0) begin
      failed++; $display("FAIL postreset_drain: left=%0d overlap=%0d, required 0 and 0", exp_q.size(), overlap_err); end
  endtask

  initial begin
    logic [DIM*DW-1:0] w;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1; num_k_tiles = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < DIM; i++) begin
        w = '0;
        w[i*DW +: DW] = 8'd1;
        mem[t*(DIM+1) + i] = w;
      end
      mem[t*(DIM+1) + DIM] = 64'h0807060504030201;
    end
    for (int c = 0; c < DIM; c++) buf_m[c] = '0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
